// File: rtl/dcpu16_pkg.sv
// rtl/dcpu16_pkg.sv - shared state encodings and constants for the DCPU16 memory bus arbiter
package dcpu16_pkg;

    // Arbiter states: waiting, fetch bus granted, A-bus granted, one-cycle cool-down
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_F = 2'd1,
        ST_GNT_A = 2'd2,
        ST_DONE  = 2'd3
    } mbus_state_t;

    // Read data returned to a master whose slave never answered
    localparam logic [15:0] TMO_DATA = 16'hFFFF;

    // Width of the per-grant wait counter
    localparam int WAIT_W = 8;

endpackage

// File: rtl/dcpu16_rrsel.sv
// rtl/dcpu16_rrsel.sv - two-request round-robin selector with one-hot grant
module dcpu16_rrsel (
    input  logic       i_req_f,
    input  logic       i_req_a,
    input  logic       i_last_a,
    output logic [1:0] o_gnt
);

    // Bit 0 grants the fetch bus, bit 1 the A-bus; a tie goes to whoever did not win last
    always_comb begin
        o_gnt = 2'b00;
        if (i_req_f && i_req_a) begin
            o_gnt = i_last_a ? 2'b01 : 2'b10;
        end else if (i_req_f) begin
            o_gnt = 2'b01;
        end else if (i_req_a) begin
            o_gnt = 2'b10;
        end
    end

endmodule

// File: rtl/dcpu16_mbus.sv
// rtl/dcpu16_mbus.sv - arbitrates fetch bus and A-bus onto a single memory port with timeout
module dcpu16_mbus
    import dcpu16_pkg::*;
#(
    parameter int FIRST = 0,
    parameter int TMO   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] fs_adr,
    input  logic        fs_stb,
    input  logic        fs_wre,
    input  logic [15:0] fs_dto,
    output logic [15:0] fs_dti,
    output logic        fs_ack,
    input  logic [15:0] ab_adr,
    input  logic        ab_stb,
    input  logic        ab_wre,
    input  logic [15:0] ab_dto,
    output logic [15:0] ab_dti,
    output logic        ab_ack,
    output logic [15:0] mm_adr,
    output logic        mm_stb,
    output logic        mm_wre,
    output logic [15:0] mm_dto,
    input  logic [15:0] mm_dti,
    input  logic        mm_ack,
    output logic        mm_err
);

    localparam logic [WAIT_W-1:0] TMO_CNT    = WAIT_W'(TMO);
    // "Last granted was A" at reset makes the first tie go to the fetch bus when FIRST is 0
    localparam logic              RST_LAST_A = (FIRST == 0);

    mbus_state_t       r_state;
    logic [WAIT_W-1:0] r_wait;
    logic              r_last_a;

    logic [1:0]  w_gnt;
    logic        w_finish;
    logic [15:0] w_rdata;

    dcpu16_rrsel u_rrsel (
        .i_req_f  (fs_stb),
        .i_req_a  (ab_stb),
        .i_last_a (r_last_a),
        .o_gnt    (w_gnt)
    );

    // A real ack always wins over a timeout landing on the same edge
    assign w_finish = mm_ack || (r_wait == TMO_CNT);
    assign w_rdata  = mm_ack ? mm_dti : TMO_DATA;

    // Arbiter FSM: latch the winner's request, wait for ack or timeout, hand data back
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_wait   <= '0;
            r_last_a <= RST_LAST_A;
            mm_adr   <= 16'h0000;
            mm_stb   <= 1'b0;
            mm_wre   <= 1'b0;
            mm_dto   <= 16'h0000;
            mm_err   <= 1'b0;
            fs_dti   <= 16'h0000;
            fs_ack   <= 1'b0;
            ab_dti   <= 16'h0000;
            ab_ack   <= 1'b0;
        end else begin
            fs_ack <= 1'b0;
            ab_ack <= 1'b0;
            mm_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt[0]) begin
                        r_state  <= ST_GNT_F;
                        r_last_a <= 1'b0;
                        r_wait   <= '0;
                        mm_adr   <= fs_adr;
                        mm_wre   <= fs_wre;
                        mm_dto   <= fs_dto;
                        mm_stb   <= 1'b1;
                    end else if (w_gnt[1]) begin
                        r_state  <= ST_GNT_A;
                        r_last_a <= 1'b1;
                        r_wait   <= '0;
                        mm_adr   <= ab_adr;
                        mm_wre   <= ab_wre;
                        mm_dto   <= ab_dto;
                        mm_stb   <= 1'b1;
                    end
                end
                ST_GNT_F, ST_GNT_A: begin
                    if (w_finish) begin
                        if (r_state == ST_GNT_F) begin
                            fs_dti <= w_rdata;
                            fs_ack <= 1'b1;
                        end else begin
                            ab_dti <= w_rdata;
                            ab_ack <= 1'b1;
                        end
                        mm_err  <= !mm_ack;
                        mm_stb  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dcpu16_mbus.md
DCPU16_MBUS -- requirements
Module: dcpu16_mbus

Interface
REQ-001 SHALL provide parameter FIRST, default 0, meaning the master favoured by the first simultaneous request after reset (0 = fetch bus, 1 = A-bus).
REQ-002 SHALL provide parameter TMO, default 15, meaning the slave-timeout limit in cycles (legal range 2..255).
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have ports, in order:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-low reset.
- fs_adr  in  16  fetch-bus address.
- fs_stb  in  1  fetch-bus request strobe.
- fs_wre  in  1  fetch-bus write enable.
- fs_dto  in  16  fetch-bus write data.
- fs_dti  out  16  fetch-bus read data.
- fs_ack  out  1  fetch-bus acknowledge.
- ab_adr  in  16  A-bus address.
- ab_stb  in  1  A-bus request strobe.
- ab_wre  in  1  A-bus write enable.
- ab_dto  in  16  A-bus write data.
- ab_dti  out  16  A-bus read data.
- ab_ack  out  1  A-bus acknowledge.
- mm_adr  out  16  memory address.
- mm_stb  out  1  memory strobe.
- mm_wre  out  1  memory write enable.
- mm_dto  out  16  memory write data.
- mm_dti  in  16  memory read data.
- mm_ack  in  1  memory acknowledge.
- mm_err  out  1  one-cycle timeout pulse.

Function
REQ-005 SHALL arbitrate the two CPU masters onto one memory port using states IDLE, GNT_F, GNT_A and DONE.
REQ-006 In IDLE with only fs_stb high, the block SHALL go to GNT_F next cycle; with only ab_stb high, it SHALL go to GNT_A.
REQ-007 In IDLE with both strobes high, the block SHALL grant the master not granted most recently (round-robin); the first tie after reset SHALL go per FIRST.
REQ-008 On entry to a grant state, the block SHALL register the winner's adr, wre and dto into mm_adr, mm_wre and mm_dto, and SHALL drive mm_stb=1 registered.
- Request-to-mm_stb latency: exactly 1 cycle.
REQ-009 mm_adr, mm_wre and mm_dto SHALL stay stable while mm_stb=1.
REQ-010 On the rising edge where mm_ack=1 in a grant state, the block SHALL register mm_dti into the granted master's dti and pulse that master's ack for exactly one cycle.
- State goes to DONE; mm_stb=0.
- Ack latency: 1 cycle after mm_ack.
REQ-011 The non-granted ack output SHALL stay 0, and its dti SHALL hold its last value.
REQ-012 DONE SHALL last exactly one cycle and then return to IDLE, so a master that drops stb after ack is never re-granted spuriously.
REQ-013 Each grant SHALL start an 8-bit wait counter at 0, incrementing each cycle mm_ack=0.
REQ-014 When the wait counter reaches TMO, the block SHALL complete the transfer as in REQ-010 with dti=16'hFFFF, drop mm_stb, and pulse mm_err for one cycle.
REQ-015 mm_ack arriving in IDLE or DONE SHALL be ignored.
REQ-016 mm_ack and timeout in the same cycle SHALL be treated as a normal ack: data = mm_dti, mm_err=0.
REQ-017 A strobe dropped by a master mid-grant SHALL NOT abort the memory cycle; the ack is still issued.
REQ-018 A write (wre=1) SHALL still return ack; the dti value is mm_dti as sampled.

Reset
REQ-019 With rst=0 at a clock edge, state SHALL become IDLE and the following SHALL be 0: mm_stb, mm_wre, fs_ack, ab_ack, mm_err, wait counter.
- mm_adr, mm_dto, fs_dti, ab_dti SHALL be 16'h0000.
- Round-robin pointer SHALL be set per FIRST.
REQ-020 Reset mid-grant SHALL abandon the transfer without an ack.

Structure
REQ-021 State encodings and the timeout-data constant 16'hFFFF SHALL live in shared package dcpu16_pkg.
REQ-022 The round-robin selector SHALL be sub-module dcpu16_rrsel (two requests, last-grant input, one-hot grant output).
REQ-023 The block SHALL be instantiated between dcpu16 and memory in the system top.

Verification
REQ-024 The bench SHALL cover:
- fs_stb=1, fs_adr=16'h0010, mm_ack one cycle after mm_stb with mm_dti=16'h7C01 -> mm_adr=16'h0010; fs_ack pulse with fs_dti=16'h7C01; ab_ack=0.
- Both strobes high from reset, FIRST=0 -> fetch granted first, then A-bus; a second tie grants the opposite of the last grant.
- ab write ab_adr=16'hFFFF, ab_dto=16'h1234 -> mm_wre=1, mm_dto=16'h1234 stable until mm_ack; one ab_ack pulse.
- mm_ack never asserted, TMO=15 -> ack with dti=16'hFFFF and a single mm_err pulse 16 cycles after mm_stb rose.
- rst=0 asserted while mm_stb=1 -> next cycle mm_stb=0 with no ack; the following request is served normally.
- mm_ack pulsed while IDLE -> no ack or state change.
